// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter.
// Every signal is level-sampled on each rising clkEn edge. There is no valid/ready
// handshake: the controller holds rst_cu/ld/cen/up/mode/pin steady across the edge,
// and the counter presents pout/co/zero/evt/busy/dbg_state for the whole cycle.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             rst_cu;
    logic             ld;
    logic             cen;
    logic             up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             co;
    logic             zero;
    logic             evt;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output rst_cu, ld, cen, up, mode, pin,
        input  pout, co, zero, evt, busy, dbg_state
    );

    modport slave (
        input  rst_cu, ld, cen, up, mode, pin,
        output pout, co, zero, evt, busy, dbg_state
    );
endinterface

// File: rtl/param_updown_counter.sv
// param_updown_counter: WIDTH-bit loadable up/down counter with wrap, saturate,
// auto-reload and one-shot modes. One-shot is sequenced by a 3-state FSM whose
// state is visible on bus.dbg_state (0 = IDLE, 1 = RUN, 2 = DONE).
// Optional feature macro: COUNTER_PRESCALE_EN -- when defined, only every
// PRESCALE-th qualifying cen cycle produces a step.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int TC_VAL   = 1,
    parameter int PRESCALE = 4
) (
    input logic                    clkEn,
    input logic                    rst,
    param_updown_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_WRAP   = 2'b00;
    localparam logic [1:0]       MODE_SAT    = 2'b01;
    localparam logic [1:0]       MODE_RELOAD = 2'b10;
    localparam logic [1:0]       MODE_ONE    = 2'b11;
    localparam logic [WIDTH-1:0] MAX_V       = '1;
    localparam logic [WIDTH-1:0] TC          = WIDTH'(TC_VAL);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             evt_q, evt_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] bnd;
    logic [WIDTH-1:0] stepped;
    logic             at_b;
    logic             lands;
    logic             qualify;
    logic             step;

    // A cycle qualifies for counting when nothing of higher priority is active
    // and, in one-shot mode, the FSM is running.
    assign qualify = bus.cen && !bus.ld && !bus.rst_cu &&
                     ((bus.mode != MODE_ONE) || (state_q == RUN));

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler: counts qualifying cycles, wraps at PRESCALE-1, cleared by rst_cu/ld.
    always_comb begin
        ps_d = ps_q;
        if (bus.rst_cu || bus.ld) begin
            ps_d = '0;
        end else if (qualify) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clkEn or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step = qualify && (ps_q == PS_LAST);
`else
    assign step = qualify;
`endif

    assign bnd     = bus.up ? MAX_V : '0;
    assign stepped = bus.up ? (pout_q + 1'b1) : (pout_q - 1'b1);
    assign at_b    = (pout_q == bnd);
    assign lands   = (stepped == bnd);

    // Next-state for counter value, reload value, event pulse and one-shot FSM.
    always_comb begin
        pout_d  = pout_q;
        rld_d   = rld_q;
        evt_d   = 1'b0;
        state_d = state_q;
        if (bus.rst_cu) begin
            pout_d  = '0;
            state_d = IDLE;
        end else if (bus.ld) begin
            pout_d  = bus.pin;
            rld_d   = bus.pin;
            state_d = (bus.mode == MODE_ONE) ? RUN : IDLE;
        end else begin
            // Leaving one-shot mode aborts any run; pout is kept.
            if (bus.mode != MODE_ONE) begin
                state_d = IDLE;
            end
            if (step) begin
                case (bus.mode)
                    MODE_WRAP: begin
                        pout_d = stepped;
                        evt_d  = at_b;
                    end
                    MODE_SAT: begin
                        if (!at_b) begin
                            pout_d = stepped;
                            evt_d  = lands;
                        end
                    end
                    MODE_RELOAD: begin
                        pout_d = at_b ? rld_q : stepped;
                        evt_d  = at_b;
                    end
                    default: begin
                        // One-shot: only reachable in RUN. Starting at B simply
                        // wraps away from it; landing on B finishes the shot.
                        pout_d = stepped;
                        if (lands) begin
                            evt_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clkEn or posedge rst) begin
        if (rst) begin
            pout_q  <= '0;
            rld_q   <= '0;
            evt_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            pout_q  <= pout_d;
            rld_q   <= rld_d;
            evt_q   <= evt_d;
            state_q <= state_d;
        end
    end

    assign bus.pout      = pout_q;
    assign bus.co        = (pout_q == TC);
    assign bus.zero      = (pout_q == '0);
    assign bus.evt       = evt_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.dbg_state = state_q;
endmodule
